// File: rtl/axis_rr_input_arbiter.sv
// Packet-granular round-robin arbiter in front of the P4 processor AXIS input.
// A port owns the output from its first accepted beat until its tlast is
// accepted; beats pass through a single output register. Per-port forwarded
// packet counters are kept for debug.
module axis_rr_input_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                                axis_aclk,
    input  logic                                axis_arst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]              m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    output logic [NUM_PORTS-1:0]                grant,
    output logic [NUM_PORTS*32-1:0]             pkt_cnt
);

    localparam int          KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned NP         = NUM_PORTS;
    localparam int          PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] next_ptr;
    logic             out_ready;
    logic             accept;
    logic             accept_last;

    // First valid requester scanning from rr_ptr upward, wrapping at NUM_PORTS
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(NUM_PORTS)) begin
                cand_sum = cand_sum - (PTR_W+1)'(NUM_PORTS);
            end
            cand = cand_sum[PTR_W-1:0];
            if (!sel_found && s_axis_tvalid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign out_ready   = !m_axis_tvalid || m_axis_tready;
    assign accept      = (state == ST_BUSY) && s_axis_tvalid[gidx] && out_ready;
    assign accept_last = accept && s_axis_tlast[gidx];
    assign next_ptr    = (gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;

    // Only the granted port sees ready, and only while the output register can take a beat
    always_comb begin
        s_axis_tready = '0;
        if (state == ST_BUSY) begin
            s_axis_tready[gidx] = out_ready;
        end
    end

    // Grant FSM: arbitrate in IDLE, hold the grant until the owner's tlast is accepted
    always_ff @(posedge axis_aclk or posedge axis_arst) begin
        if (axis_arst) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            gidx   <= '0;
            grant  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        state <= ST_BUSY;
                        gidx  <= sel_idx;
                        grant <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel_idx;
                    end
                end
                ST_BUSY: begin
                    if (accept_last) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Output register: load on accept, drop valid once the consumer takes the beat
    always_ff @(posedge axis_aclk or posedge axis_arst) begin
        if (axis_arst) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            m_axis_tdata  <= s_axis_tdata[gidx*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep  <= s_axis_tkeep[gidx*KEEP_WIDTH +: KEEP_WIDTH];
            m_axis_tuser  <= s_axis_tuser[gidx*TUSER_WIDTH +: TUSER_WIDTH];
            m_axis_tlast  <= s_axis_tlast[gidx];
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
        logic [31:0] cnt_q;

        // Count packets whose tlast was accepted from this port; wraps silently
        always_ff @(posedge axis_aclk or posedge axis_arst) begin
            if (axis_arst) begin
                cnt_q <= '0;
            end else if (accept_last && (gidx == PTR_W'(i))) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end

        assign pkt_cnt[i*32 +: 32] = cnt_q;
    end

endmodule

// File: tb/tb_axis_rr_input_arbiter.sv
// Directed bench for axis_rr_input_arbiter: per-port beat queues feed the
// inputs, accepted output beats are logged and compared with hand-built lists.
module tb_axis_rr_input_arbiter;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int TW = 128;
    localparam int KW = DW / 8;

    typedef logic [8:0] beat_t;   // {tlast, tdata[7:0]}

    logic              axis_aclk = 1'b0;
    logic              axis_arst;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP*TW-1:0]  s_axis_tuser;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [TW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [NP-1:0]     grant;
    logic [NP*32-1:0]  pkt_cnt;

    beat_t         srcq [NP][$];
    beat_t         outlog [$];
    beat_t         expq [$];
    logic [NP-1:0] grantlog [$];
    logic [NP-1:0] prev_grant;
    int unsigned   n_total = 0;
    int unsigned   n_bad   = 0;
    int unsigned   n;

    axis_rr_input_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .TUSER_WIDTH(TW)
    ) dut (
        .axis_aclk    (axis_aclk),
        .axis_arst    (axis_arst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant        (grant),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 axis_aclk = ~axis_aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int p);
        return pkt_cnt[p*32 +: 32];
    endfunction

    function automatic bit src_pending();
        bit any = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (srcq[p].size() != 0) any = 1'b1;
        end
        return any;
    endfunction

    // Present each queue head on its port
    task automatic drive();
        beat_t hd;
        for (int p = 0; p < NP; p++) begin
            if (srcq[p].size() != 0) begin
                hd = srcq[p][0];
                s_axis_tvalid[p]          = 1'b1;
                s_axis_tlast[p]           = hd[8];
                s_axis_tdata[p*DW +: DW]  = DW'(hd[7:0]);
                s_axis_tuser[p*TW +: TW]  = TW'(hd[7:0] ^ 8'hFF);
            end else begin
                s_axis_tvalid[p]          = 1'b0;
                s_axis_tlast[p]           = 1'b0;
                s_axis_tdata[p*DW +: DW]  = DW'(8'hEE);
                s_axis_tuser[p*TW +: TW]  = '0;
            end
        end
    endtask

    // One clock: record handshakes that happen at the coming edge, then move to the next falling edge
    task automatic step();
        #1;
        if (m_axis_tvalid && m_axis_tready) outlog.push_back({m_axis_tlast, m_axis_tdata[7:0]});
        for (int p = 0; p < NP; p++) begin
            if (s_axis_tvalid[p] && s_axis_tready[p]) srcq[p].delete(0);
        end
        @(negedge axis_aclk);
        drive();
        if (grant != '0 && prev_grant == '0) grantlog.push_back(grant);
        prev_grant = grant;
    endtask

    task automatic drain();
        int unsigned k;
        k = 0;
        while (k < 60 && (src_pending() || m_axis_tvalid || grant != '0)) begin
            step();
            k++;
        end
        check("drain_bound", 64'(k < 60), 64'd1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 64'(outlog.size()), 64'(expq.size()));
        for (int i = 0; i < outlog.size() && i < expq.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), 64'(outlog[i]), 64'(expq[i]));
        end
        outlog.delete();
        expq.delete();
    endtask

    task automatic apply_reset();
        axis_arst = 1'b1;
        step();
        axis_arst = 1'b0;
        outlog.delete();
        grantlog.delete();
        prev_grant = '0;
    endtask

    initial begin
        axis_arst     = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tkeep  = '1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        prev_grant    = '0;
        drive();
        @(negedge axis_aclk);

        // Reset state
        check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_mlast",  64'(m_axis_tlast),  64'd0);
        check("rst_grant",  64'(grant),         64'd0);
        check("rst_sready", 64'(s_axis_tready), 64'd0);
        check("rst_cnt",    64'(pkt_cnt != '0), 64'd0);
        axis_arst = 1'b0;

        // T1: single 3-beat packet on port0
        srcq[0].push_back(9'h0A1); srcq[0].push_back(9'h0A2); srcq[0].push_back(9'h1A3);
        drive();
        step();
        check("t1_grant",   64'(grant),         64'h1);
        check("t1_mvalid0", 64'(m_axis_tvalid), 64'd0);
        check("t1_sready",  64'(s_axis_tready), 64'h1);
        step();
        check("t1_mvalid1", 64'(m_axis_tvalid),     64'd1);
        check("t1_data1",   64'(m_axis_tdata[7:0]), 64'hA1);
        check("t1_user1",   64'(m_axis_tuser[7:0]), 64'h5E);
        check("t1_keep1",   64'(m_axis_tkeep),      64'hFFFF_FFFF);
        check("t1_last1",   64'(m_axis_tlast),      64'd0);
        step();
        check("t1_data2",   64'(m_axis_tdata[7:0]), 64'hA2);
        step();
        check("t1_data3",   64'(m_axis_tdata[7:0]), 64'hA3);
        check("t1_last3",   64'(m_axis_tlast),      64'd1);
        check("t1_grant_end", 64'(grant),           64'd0);
        check("t1_cnt0",    64'(cnt(0)),            64'd1);
        step();
        check("t1_mvalid_end", 64'(m_axis_tvalid),  64'd0);
        drain();
        expq.push_back(9'h0A1); expq.push_back(9'h0A2); expq.push_back(9'h1A3);
        check_log("t1");

        // T2: all ports request continuously; port0 has a second packet
        apply_reset();
        srcq[0].push_back(9'h001); srcq[0].push_back(9'h102);
        srcq[0].push_back(9'h003); srcq[0].push_back(9'h104);
        srcq[1].push_back(9'h011); srcq[1].push_back(9'h112);
        srcq[2].push_back(9'h021); srcq[2].push_back(9'h122);
        srcq[3].push_back(9'h031); srcq[3].push_back(9'h132);
        drive();
        n = 0;
        while (outlog.size() < 10 && n < 60) begin
            step();
            n++;
        end
        check("t2_cycles", 64'(n), 64'd16);
        drain();
        expq.push_back(9'h001); expq.push_back(9'h102);
        expq.push_back(9'h011); expq.push_back(9'h112);
        expq.push_back(9'h021); expq.push_back(9'h122);
        expq.push_back(9'h031); expq.push_back(9'h132);
        expq.push_back(9'h003); expq.push_back(9'h104);
        check_log("t2");
        check("t2_grants", 64'(grantlog.size()), 64'd5);
        if (grantlog.size() == 5) begin
            check("t2_g0", 64'(grantlog[0]), 64'h1);
            check("t2_g1", 64'(grantlog[1]), 64'h2);
            check("t2_g2", 64'(grantlog[2]), 64'h4);
            check("t2_g3", 64'(grantlog[3]), 64'h8);
            check("t2_g4", 64'(grantlog[4]), 64'h1);
        end
        check("t2_cnt0", 64'(cnt(0)), 64'd2);
        check("t2_cnt3", 64'(cnt(3)), 64'd1);

        // T3: backpressure during a 4-beat packet on port1
        srcq[1].push_back(9'h0B1); srcq[1].push_back(9'h0B2);
        srcq[1].push_back(9'h0B3); srcq[1].push_back(9'h1B4);
        drive();
        step();
        check("t3_grant", 64'(grant), 64'h2);
        step();
        check("t3_data_b1", 64'(m_axis_tdata[7:0]), 64'hB1);
        m_axis_tready = 1'b0;
        #1;
        check("t3_sready_stall0", 64'(s_axis_tready), 64'd0);
        step();
        check("t3_hold_valid", 64'(m_axis_tvalid),     64'd1);
        check("t3_hold_data1", 64'(m_axis_tdata[7:0]), 64'hB1);
        check("t3_sready_stall1", 64'(s_axis_tready),  64'd0);
        step();
        check("t3_hold_data2", 64'(m_axis_tdata[7:0]), 64'hB1);
        check("t3_hold_last",  64'(m_axis_tlast),      64'd0);
        m_axis_tready = 1'b1;
        step();
        check("t3_data_b2", 64'(m_axis_tdata[7:0]), 64'hB2);
        drain();
        expq.push_back(9'h0B1); expq.push_back(9'h0B2);
        expq.push_back(9'h0B3); expq.push_back(9'h1B4);
        check_log("t3");

        // T4: port1 requests while port2 is mid-packet
        srcq[2].push_back(9'h0C1); srcq[2].push_back(9'h0C2); srcq[2].push_back(9'h1C3);
        drive();
        step();
        check("t4_grant2", 64'(grant), 64'h4);
        step();
        srcq[1].push_back(9'h1D1);
        drive();
        #1;
        check("t4_sready_a", 64'(s_axis_tready), 64'h4);
        step();
        check("t4_sready_b", 64'(s_axis_tready), 64'h4);
        check("t4_grant_hold", 64'(grant),       64'h4);
        step();
        check("t4_grant_idle", 64'(grant),         64'd0);
        check("t4_sready_idle", 64'(s_axis_tready), 64'd0);
        step();
        check("t4_grant1", 64'(grant), 64'h2);
        drain();
        expq.push_back(9'h0C1); expq.push_back(9'h0C2);
        expq.push_back(9'h1C3); expq.push_back(9'h1D1);
        check_log("t4");

        // T5: reset after beat 2 of a 5-beat packet on port3
        srcq[3].push_back(9'h0E1); srcq[3].push_back(9'h0E2); srcq[3].push_back(9'h0E3);
        srcq[3].push_back(9'h0E4); srcq[3].push_back(9'h1E5);
        drive();
        step();
        check("t5_grant3", 64'(grant), 64'h8);
        step();
        step();
        check("t5_pre_log", 64'(outlog.size()), 64'd1);
        axis_arst = 1'b1;
        srcq[0].push_back(9'h1F1);
        drive();
        #1;
        check("t5_mvalid", 64'(m_axis_tvalid),  64'd0);
        check("t5_grant",  64'(grant),          64'd0);
        check("t5_cnt",    64'(pkt_cnt != '0),  64'd0);
        check("t5_rr_ptr", 64'(dut.rr_ptr),     64'd0);
        step();
        axis_arst = 1'b0;
        outlog.delete();
        step();
        check("t5_grant0", 64'(grant), 64'h1);
        drain();
        expq.push_back(9'h1F1); expq.push_back(9'h0E3);
        expq.push_back(9'h0E4); expq.push_back(9'h1E5);
        check_log("t5");
        check("t5_cnt3", 64'(cnt(3)), 64'd1);

        // T6: counter wrap on port3
        force dut.g_cnt[3].cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.g_cnt[3].cnt_q;
        check("t6_cnt_pre", 64'(cnt(3)), 64'hFFFF_FFFF);
        srcq[3].push_back(9'h161);
        drive();
        step();
        check("t6_grant3", 64'(grant), 64'h8);
        step();
        check("t6_cnt_wrap", 64'(cnt(3)),            64'd0);
        check("t6_data",     64'(m_axis_tdata[7:0]), 64'h61);
        check("t6_last",     64'(m_axis_tlast),      64'd1);
        check("t6_cnt0",     64'(cnt(0)),            64'd1);
        drain();
        expq.push_back(9'h161);
        check_log("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
